// File: rtl/rotate_ctrl_if.sv
// Control/status bundle between the rotation controller and its user:
// switch/button inputs in, mux select and status out.
interface rotate_ctrl_if;
  logic       run;
  logic       step_n;
  logic       dir;
  logic [1:0] speed;
  logic [2:0] sel;
  logic       tick;
  logic       running;

  modport master (output run, step_n, dir, speed, input sel, tick, running);
  modport slave  (input run, step_n, dir, speed, output sel, tick, running);
endinterface

// File: rtl/rotate_ctrl.sv
// Rotation index generator for the seven-digit rotating display: auto-advance
// at a programmable rate while running, single steps on button presses while paused.
module rotate_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int NUM_POS  = 7
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  rotate_ctrl_if.slave  bus
);

  localparam int         CW   = $clog2(TICK_DIV);
  localparam logic [2:0] LAST = 3'(NUM_POS - 1);

  typedef enum logic {PAUSED = 1'b0, RUNNING = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic          run_meta_reg, run_s_reg;
  logic          step_meta_reg, step_s_reg, step_d_reg;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    sel_reg, sel_next;
  logic          tick_reg, running_reg;
  logic          press, advance, terminal;
  logic [31:0]   limit;

  assign press = ~step_s_reg & step_d_reg;

  // Compare with >= so a speed-up mid-count fires on the next cycle rather than wrapping.
  assign limit    = (32'(TICK_DIV) >> bus.speed) - 32'd1;
  assign terminal = 32'(cnt_reg) >= limit;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    advance    = 1'b0;
    sel_next   = sel_reg;
    if (state_reg == RUNNING) begin
      if (terminal) begin
        cnt_next = '0;
        advance  = 1'b1;
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
      if (!run_s_reg) state_next = PAUSED;
    end else begin
      cnt_next = '0;
      advance  = press;
      if (run_s_reg) state_next = RUNNING;
    end
    if (advance) begin
      if (bus.dir) sel_next = (sel_reg == 3'd0) ? LAST : sel_reg - 3'd1;
      else         sel_next = (sel_reg == LAST) ? 3'd0 : sel_reg + 3'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      run_meta_reg  <= 1'b0;
      run_s_reg     <= 1'b0;
      step_meta_reg <= 1'b1;
      step_s_reg    <= 1'b1;
      step_d_reg    <= 1'b1;
      state_reg     <= PAUSED;
      cnt_reg       <= '0;
      sel_reg       <= 3'd0;
      tick_reg      <= 1'b0;
      running_reg   <= 1'b0;
    end else begin
      run_meta_reg  <= bus.run;
      run_s_reg     <= run_meta_reg;
      step_meta_reg <= bus.step_n;
      step_s_reg    <= step_meta_reg;
      step_d_reg    <= step_s_reg;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      sel_reg       <= sel_next;
      tick_reg      <= advance;
      running_reg   <= (state_next == RUNNING);
    end
  end

  assign bus.sel     = sel_reg;
  assign bus.tick    = tick_reg;
  assign bus.running = running_reg;

endmodule

// File: tb/tb_rotate_ctrl.sv
// Bench for rotate_ctrl: scenario tasks with randomized directions/speeds,
// expectations from modular position arithmetic and period = TICK_DIV / 2^speed.
module tb_rotate_ctrl;
  localparam int TICK_DIV = 16;
  localparam int NUM_POS  = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  rotate_ctrl_if bus();

  rotate_ctrl #(.TICK_DIV(TICK_DIV), .NUM_POS(NUM_POS)) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_sel  = 0;

  // Reference: position on a ring of NUM_POS, and advance period in cycles.
  function automatic int ref_next(input int s, input bit d);
    return d ? (s + NUM_POS - 1) % NUM_POS : (s + 1) % NUM_POS;
  endfunction

  function automatic int ref_period(input int sp);
    return TICK_DIV / (1 << sp);
  endfunction

  task automatic wait_tick(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_press(input bit d, input int hold, output int first_at, output int count);
    first_at = -1;
    count    = 0;
    bus.dir    = d;
    bus.step_n = 1'b0;
    for (int i = 1; i <= hold + 6; i++) begin
      @(negedge clk);
      if (i == hold) bus.step_n = 1'b1;
      if (bus.tick === 1'b1) begin
        count++;
        if (first_at < 0) first_at = i;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.sel, bus.tick, bus.running} !== 5'b0 || dut.cnt_reg !== '0) begin
      n_fail++;
      $display("FAIL reset_state: sel=%0d tick=%0b running=%0b cnt=%0d, required all 0",
               bus.sel, bus.tick, bus.running, dut.cnt_reg);
    end
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.sel, bus.tick, bus.running} !== 5'b0) begin
        n_fail++;
        $display("FAIL idle_after_reset cycle %0d: sel=%0d tick=%0b running=%0b, required 0/0/0",
                 i, bus.sel, bus.tick, bus.running);
      end
    end
    $display("reset: idle 100 cycles checked");
  endtask

  task automatic test_auto_rotate;
    int n;
    bus.speed = 2'd0;
    bus.dir   = 1'b0;
    bus.run   = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.running !== 1'b0) begin
      n_fail++;
      $display("FAIL run_latency_early: running=%0b, required 0 after 2 edges", bus.running);
    end
    @(negedge clk);
    n_checks++;
    if (bus.running !== 1'b1) begin
      n_fail++;
      $display("FAIL run_latency: running=%0b, required 1 after 3 edges", bus.running);
    end
    for (int k = 0; k < 8; k++) begin
      wait_tick(40, n);
      exp_sel = ref_next(exp_sel, 1'b0);
      n_checks++;
      if (n !== ref_period(0) || int'(bus.sel) !== exp_sel) begin
        n_fail++;
        $display("FAIL auto_rotate %0d: interval=%0d sel=%0d, required interval=%0d sel=%0d",
                 k, n, bus.sel, ref_period(0), exp_sel);
      end
      $display("auto tick %0d: interval %0d sel %0d", k, n, bus.sel);
    end
  endtask

  task automatic test_reverse_speed;
    int n;
    bus.speed = 2'd3;
    bus.dir   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_tick(20, n);
      exp_sel = ref_next(exp_sel, 1'b1);
      n_checks++;
      if (n !== ref_period(3) || int'(bus.sel) !== exp_sel) begin
        n_fail++;
        $display("FAIL reverse_fast %0d: interval=%0d sel=%0d, required interval=%0d sel=%0d",
                 k, n, bus.sel, ref_period(3), exp_sel);
      end
      $display("reverse tick %0d: interval %0d sel %0d", k, n, bus.sel);
    end
    @(negedge clk);
    n_checks++;
    if (dut.cnt_reg !== 1) begin
      n_fail++;
      $display("FAIL prescaler_mid: cnt=%0d, required 1", dut.cnt_reg);
    end
    bus.speed = 2'd0;
    wait_tick(40, n);
    exp_sel = ref_next(exp_sel, 1'b1);
    n_checks++;
    if (n !== ref_period(0) - 1 || int'(bus.sel) !== exp_sel) begin
      n_fail++;
      $display("FAIL slow_down_mid: interval=%0d sel=%0d, required interval=%0d sel=%0d",
               n, bus.sel, ref_period(0) - 1, exp_sel);
    end
    $display("slow-down: interval %0d sel %0d", n, bus.sel);
  endtask

  task automatic test_reset_mid;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.sel, bus.tick, bus.running} !== 5'b0 || dut.cnt_reg !== '0) begin
      n_fail++;
      $display("FAIL async_reset: sel=%0d tick=%0b running=%0b cnt=%0d, required all 0",
               bus.sel, bus.tick, bus.running, dut.cnt_reg);
    end
    exp_sel = 0;
    bus.run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.sel, bus.tick, bus.running} !== 5'b0) begin
        n_fail++;
        $display("FAIL idle_after_mid_reset cycle %0d: sel=%0d tick=%0b running=%0b, required 0/0/0",
                 i, bus.sel, bus.tick, bus.running);
      end
    end
    $display("mid-run reset: outputs cleared, idle 100 cycles checked");
  endtask

  task automatic test_step_paused;
    int at, cnt;
    bit d;
    int hold;
    // 0 -> 6 (dir 1), 6 -> 0 with a 50-cycle hold (dir 0), 0 -> 6 (dir 1), then random presses
    for (int k = 0; k < 9; k++) begin
      if (k == 0 || k == 2) begin d = 1'b1; hold = 4; end
      else if (k == 1)      begin d = 1'b0; hold = 50; end
      else begin
        d    = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 12));
      end
      do_press(d, hold, at, cnt);
      exp_sel = ref_next(exp_sel, d);
      n_checks++;
      if (cnt !== 1 || at !== 3 || int'(bus.sel) !== exp_sel) begin
        n_fail++;
        $display("FAIL step_paused %0d: ticks=%0d at=%0d sel=%0d, required ticks=1 at=3 sel=%0d",
                 k, cnt, at, bus.sel, exp_sel);
      end
      $display("press %0d: dir %0b hold %0d ticks %0d sel %0d", k, d, hold, cnt, bus.sel);
    end
  endtask

  task automatic test_step_running;
    int n;
    bit d;
    d = 1'($urandom_range(0, 1));
    bus.dir   = d;
    bus.speed = 2'd0;
    bus.run   = 1'b1;
    wait_tick(60, n);
    exp_sel = ref_next(exp_sel, d);
    n_checks++;
    if (n !== 3 + ref_period(0) || int'(bus.sel) !== exp_sel) begin
      n_fail++;
      $display("FAIL first_advance: interval=%0d sel=%0d, required interval=%0d sel=%0d",
               n, bus.sel, 3 + ref_period(0), exp_sel);
    end
    for (int k = 0; k < 4; k++) begin
      d = 1'($urandom_range(0, 1));
      bus.dir = d;
      n = -1;
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (i == 5) bus.step_n = 1'b0;
        if (i == 8) bus.step_n = 1'b1;
        if (bus.tick === 1'b1) begin
          n = i;
          break;
        end
      end
      exp_sel = ref_next(exp_sel, d);
      n_checks++;
      if (n !== ref_period(0) || int'(bus.sel) !== exp_sel) begin
        n_fail++;
        $display("FAIL step_running %0d: interval=%0d sel=%0d, required interval=%0d sel=%0d",
                 k, n, bus.sel, ref_period(0), exp_sel);
      end
      $display("press while running %0d: interval %0d sel %0d", k, n, bus.sel);
    end
  endtask

  task automatic test_random_auto;
    int n, sp;
    bit d;
    for (int k = 0; k < 12; k++) begin
      sp = int'($urandom_range(0, 3));
      d  = 1'($urandom_range(0, 1));
      bus.speed = 2'(sp);
      bus.dir   = d;
      wait_tick(40, n);
      exp_sel = ref_next(exp_sel, d);
      n_checks++;
      if (n !== ref_period(sp) || int'(bus.sel) !== exp_sel) begin
        n_fail++;
        $display("FAIL random_auto %0d: interval=%0d sel=%0d, required interval=%0d sel=%0d",
                 k, n, bus.sel, ref_period(sp), exp_sel);
      end
      $display("random tick %0d: speed %0d dir %0b interval %0d sel %0d", k, sp, d, n, bus.sel);
    end
  endtask

  task automatic test_simultaneous;
    int n, extra;
    bus.speed = 2'd0;
    wait_tick(40, n);
    exp_sel = ref_next(exp_sel, bus.dir);
    n_checks++;
    if (n !== ref_period(0) || int'(bus.sel) !== exp_sel) begin
      n_fail++;
      $display("FAIL align_tick: interval=%0d sel=%0d, required interval=%0d sel=%0d",
               n, bus.sel, ref_period(0), exp_sel);
    end
    // run_s falls in the cycle the prescaler sits at its terminal count
    repeat (ref_period(0) - 3) @(negedge clk);
    bus.run = 1'b0;
    wait_tick(10, n);
    exp_sel = ref_next(exp_sel, bus.dir);
    n_checks++;
    if (n !== 3 || int'(bus.sel) !== exp_sel || bus.running !== 1'b0 || dut.cnt_reg !== '0) begin
      n_fail++;
      $display("FAIL terminal_on_stop: at=%0d sel=%0d running=%0b cnt=%0d, required at=3 sel=%0d running=0 cnt=0",
               n, bus.sel, bus.running, dut.cnt_reg, exp_sel);
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.tick === 1'b1 || dut.cnt_reg !== '0) extra++;
    end
    n_checks++;
    if (extra !== 0 || int'(bus.sel) !== exp_sel) begin
      n_fail++;
      $display("FAIL quiet_after_stop: bad cycles=%0d sel=%0d, required 0 and sel=%0d",
               extra, bus.sel, exp_sel);
    end
    $display("stop on terminal: sel %0d, paused", bus.sel);
  endtask

  task automatic test_press_on_run_rise;
    int n;
    bit d;
    d = 1'($urandom_range(0, 1));
    bus.dir    = d;
    bus.run    = 1'b1;
    bus.step_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.tick !== 1'b0) begin
      n_fail++;
      $display("FAIL rise_press_early: tick=%0b, required 0", bus.tick);
    end
    @(negedge clk);
    bus.step_n = 1'b1;
    exp_sel = ref_next(exp_sel, d);
    n_checks++;
    if (bus.tick !== 1'b1 || bus.running !== 1'b1 || int'(bus.sel) !== exp_sel) begin
      n_fail++;
      $display("FAIL rise_press: tick=%0b running=%0b sel=%0d, required 1/1/%0d",
               bus.tick, bus.running, bus.sel, exp_sel);
    end
    wait_tick(40, n);
    exp_sel = ref_next(exp_sel, d);
    n_checks++;
    if (n !== ref_period(0) || int'(bus.sel) !== exp_sel) begin
      n_fail++;
      $display("FAIL rise_press_next: interval=%0d sel=%0d, required interval=%0d sel=%0d",
               n, bus.sel, ref_period(0), exp_sel);
    end
    $display("press on run rise: sel %0d, next interval %0d", bus.sel, n);
    bus.run = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    bus.run    = 1'b0;
    bus.step_n = 1'b1;
    bus.dir    = 1'b0;
    bus.speed  = 2'd0;
    test_reset();
    test_auto_rotate();
    test_reverse_speed();
    test_reset_mid();
    test_step_paused();
    test_step_running();
    test_random_auto();
    test_simultaneous();
    test_press_on_run_rise();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
